// File: rtl/poly_shift_reg.sv
// Shift / XNOR polynomial register for the POKEY noise and serial paths.
// It has a long mode and a short mode, parallel load, a lock flag and a registered wrap pulse.
module poly_shift_reg #(
  parameter int WIDTH     = 17,
  parameter int TAP       = 11,
  parameter int ALT_WIDTH = 9,
  parameter int ALT_TAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enp,
  input  logic             shift,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             mode,
  input  logic             short,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             lock,
  output logic             wrap
);

  // Builds a mask with the low len bits set.
  function automatic logic [WIDTH-1:0] low_mask(input int len);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < len) m[i] = 1'b1;
      else         m[i] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] LONG_MASK = low_mask(WIDTH);
  localparam logic [WIDTH-1:0] ALT_MASK  = low_mask(ALT_WIDTH);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] mask_s;
  logic             msb_s;
  logic             tap_s;
  logic             lock_s;
  logic             in_s;
  logic [WIDTH-1:0] shifted_s;
  logic             wraps_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             wrap_nxt_s;

  // Active-length selection, feedback bit and candidate shifted value.
  always_comb begin
    mask_s    = short ? ALT_MASK : LONG_MASK;
    msb_s     = short ? q_r[ALT_WIDTH-1] : q_r[WIDTH-1];
    tap_s     = short ? q_r[ALT_TAP] : q_r[TAP];
    lock_s    = mode & ((q_r & mask_s) == mask_s);
    // A forced 0 breaks out of the all-ones XNOR lock state in one shift.
    if (!mode)       in_s = d;
    else if (lock_s) in_s = 1'b0;
    else             in_s = ~(msb_s ^ tap_s);
    shifted_s = {q_r[WIDTH-2:0], in_s};
    wraps_s   = mode & ((shifted_s & mask_s) == '0);
  end

  // Update priority under enable: clear, then load, then shift.
  always_comb begin
    q_nxt_s    = q_r;
    wrap_nxt_s = 1'b0;
    if (enp) begin
      if (r) begin
        q_nxt_s = '0;
      end else if (load) begin
        q_nxt_s = ld_data;
      end else if (shift) begin
        q_nxt_s    = shifted_s;
        wrap_nxt_s = wraps_s;
      end else begin
        q_nxt_s = q_r;
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign q     = q_r;
  assign s_out = msb_s;
  assign lock  = lock_s;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_poly_shift_reg.sv
// Self-checking bench for poly_shift_reg with WIDTH=4, TAP=2, ALT_WIDTH=3, ALT_TAP=1.
// It uses a vector table, hand-written corner sequences and random stimulus checked against an arithmetic model.
module tb_poly_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       enp, shift, r, load, mode, short, d;
  logic [3:0] ld_data;
  logic [3:0] q;
  logic       s_out, lock, wrap;

  int checks = 0;
  int errors = 0;
  int m_q    = 0;
  bit m_wrap = 1'b0;

  poly_shift_reg #(.WIDTH(4), .TAP(2), .ALT_WIDTH(3), .ALT_TAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .enp(enp), .shift(shift), .r(r), .load(load),
    .ld_data(ld_data), .mode(mode), .short(short), .d(d),
    .q(q), .s_out(s_out), .lock(lock), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       enp, shift, r, load, mode, sht, d;
    logic [3:0] ld;
    logic [3:0] eq;
    logic       ew, el;
  } vec_t;

  function automatic vec_t mk(input logic en, sh, rr, ld, md, st, dd,
                              input logic [3:0] ldd, input logic [3:0] eq,
                              input logic ew, el);
    vec_t v;
    v.enp = en; v.shift = sh; v.r = rr; v.load = ld; v.mode = md; v.sht = st; v.d = dd;
    v.ld = ldd; v.eq = eq; v.ew = ew; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_len();
    return short ? 3 : 4;
  endfunction

  function automatic bit model_lock();
    int md;
    md = 1 << act_len();
    return mode && ((m_q % md) == md - 1);
  endfunction

  function automatic bit model_sout();
    return ((m_q >> (act_len() - 1)) & 1) == 1;
  endfunction

  // Advances the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    int len, tp, md, in_b;
    len = act_len();
    tp  = short ? 1 : 2;
    md  = 1 << len;
    if (!enp) m_wrap = 1'b0;
    else if (r) begin m_q = 0; m_wrap = 1'b0; end
    else if (load) begin m_q = int'(ld_data); m_wrap = 1'b0; end
    else if (shift) begin
      if (!mode) in_b = int'(d);
      else if ((m_q % md) == md - 1) in_b = 0;
      else in_b = (((m_q >> (len - 1)) & 1) == ((m_q >> tp) & 1)) ? 1 : 0;
      m_q    = (m_q * 2 + in_b) % 16;
      m_wrap = mode && ((m_q % md) == 0);
    end else m_wrap = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(m_q));
    chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, "_lock"}, 32'(lock), 32'(model_lock()));
    chk({tag, "_sout"}, 32'(s_out), 32'(model_sout()));
  endtask

  task automatic set_in(input logic en, sh, rr, ld, md, st, dd, input logic [3:0] ldd);
    enp = en; shift = sh; r = rr; load = ld; mode = md; short = st; d = dd; ld_data = ldd;
  endtask

  vec_t tbl[18];
  bit   lock_seen;

  initial begin
    tbl[0]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b0001, 0, 0);
    tbl[1]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b0011, 0, 0);
    tbl[2]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b0111, 0, 0);
    tbl[3]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b1110, 0, 0);
    tbl[4]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b1101, 0, 0);
    tbl[5]  = mk(1,0,0,1,1,0,0, 4'hF, 4'b1111, 0, 1);
    tbl[6]  = mk(1,1,0,0,1,0,0, 4'h0, 4'b1110, 0, 0);
    tbl[7]  = mk(1,1,1,1,1,0,0, 4'h5, 4'b0000, 0, 0);
    tbl[8]  = mk(1,1,0,0,0,0,0, 4'h0, 4'b0000, 0, 0);
    tbl[9]  = mk(1,1,0,0,0,0,1, 4'h0, 4'b0001, 0, 0);
    tbl[10] = mk(1,1,0,0,0,0,0, 4'h0, 4'b0010, 0, 0);
    tbl[11] = mk(1,1,0,0,0,0,1, 4'h0, 4'b0101, 0, 0);
    tbl[12] = mk(1,1,0,0,0,0,1, 4'h0, 4'b1011, 0, 0);
    tbl[13] = mk(0,1,0,0,1,0,0, 4'h0, 4'b1011, 0, 0);
    tbl[14] = mk(1,1,0,0,1,0,0, 4'h0, 4'b0110, 0, 0);
    tbl[15] = mk(0,1,0,0,1,0,0, 4'h0, 4'b0110, 0, 0);
    tbl[16] = mk(1,1,0,0,1,0,0, 4'h0, 4'b1100, 0, 0);
    tbl[17] = mk(0,1,1,1,1,0,0, 4'h0, 4'b1100, 0, 0);

    rst_n = 1'b0;
    set_in(0,0,0,0,1,0,0, 4'h0);
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_lock", 32'(lock), 32'h0);
    chk("reset_sout", 32'(s_out), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].enp, tbl[i].shift, tbl[i].r, tbl[i].load, tbl[i].mode, tbl[i].sht,
             tbl[i].d, tbl[i].ld);
      edge_step();
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].ew));
      chk($sformatf("vec%0d_lock", i), 32'(lock), 32'(tbl[i].el));
      chk($sformatf("vec%0d_sout", i), 32'(s_out), 32'(tbl[i].eq[3]));
    end

    // Asynchronous reset between edges, then restart from 0001.
    set_in(1,1,0,0,1,0,0, 4'h0);
    edge_step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_wrap", 32'(wrap), 32'h0);
    m_q = 0; m_wrap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();
    chk("restart_q", 32'(q), 32'h1);

    // Long mode full period: back to 0000 on the 15th shift, wrap for one cycle only.
    set_in(1,0,1,0,1,0,0, 4'h0);
    edge_step();
    set_in(1,1,0,0,1,0,0, 4'h0);
    for (int i = 1; i <= 15; i++) begin
      edge_step();
      if (i < 15) begin
        chk($sformatf("long%0d_wrap", i), 32'(wrap), 32'h0);
        chk($sformatf("long%0d_nonzero", i), 32'(q != 4'h0), 32'h1);
      end else begin
        chk("long15_q", 32'(q), 32'h0);
        chk("long15_wrap", 32'(wrap), 32'h1);
      end
    end
    edge_step();
    chk("long16_q", 32'(q), 32'h1);
    chk("long16_wrap", 32'(wrap), 32'h0);

    // Short mode period of 7, lock never reached.
    set_in(1,0,1,0,1,1,0, 4'h0);
    edge_step();
    set_in(1,1,0,0,1,1,0, 4'h0);
    lock_seen = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      edge_step();
      if (lock) lock_seen = 1'b1;
      chk_model($sformatf("short%0d", i));
      if (i < 7) chk($sformatf("short%0d_nowrap", i), 32'(wrap), 32'h0);
    end
    chk("short7_low", 32'(q[2:0]), 32'h0);
    chk("short7_wrap", 32'(wrap), 32'h1);
    chk("short_lock_seen", 32'(lock_seen), 32'h0);
    edge_step();
    chk("short8_wrap", 32'(wrap), 32'h0);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
             ($urandom % 10) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom));
      edge_step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
